// File: rtl/galois_lfsr_stream.sv
// Galois LFSR PRBS source: W-bit register, N bits per beat, runtime seed load, valid/ready output.
// Latency: one cycle in INIT after reset or seed_load, then one beat per clock with zero bubbles.
// Backpressure: a presented beat is held (data and LFSR frozen) until out_valid && out_ready.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   enable                permits generation of new beats (never drops a presented beat)
//   seed_load, seed_value single-cycle reload request; zero seed is replaced by 1
//   out_data/out_valid    registered beat, out_data[N-1] is the oldest bit
//   out_ready             consumer accept
//   seed_err              one-cycle pulse after a zero seed was replaced
//   beat_count            accepted beats since reset or seed_load, wraps
//   lfsr_state            current LFSR register (debug)
module galois_lfsr_stream #(
    parameter int                    LFSR_WIDTH  = 8,
    parameter logic [LFSR_WIDTH-1:0] LFSR_POLY   = 8'h1D,
    parameter logic [LFSR_WIDTH-1:0] LFSR_SEED   = {{(LFSR_WIDTH-1){1'b0}}, 1'b1},
    parameter int                    OUT_BITS    = 1,
    parameter int                    COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic                   seed_load,
    input  logic [LFSR_WIDTH-1:0]  seed_value,
    output logic [OUT_BITS-1:0]    out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   seed_err,
    output logic [COUNT_WIDTH-1:0] beat_count,
    output logic [LFSR_WIDTH-1:0]  lfsr_state
);

    localparam logic [LFSR_WIDTH-1:0]  LFSR_ONE = {{(LFSR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (LFSR_WIDTH < 2 || LFSR_WIDTH > 32) begin : g_bad_width
        $error("galois_lfsr_stream: LFSR_WIDTH must be 2..32");
    end
    if (OUT_BITS < 1 || OUT_BITS > LFSR_WIDTH) begin : g_bad_out_bits
        $error("galois_lfsr_stream: OUT_BITS must be 1..LFSR_WIDTH");
    end
    if (LFSR_SEED == '0) begin : g_bad_seed
        $error("galois_lfsr_stream: LFSR_SEED must be nonzero");
    end
    if (LFSR_POLY[0] != 1'b1) begin : g_bad_poly
        $error("galois_lfsr_stream: LFSR_POLY bit 0 must be 1");
    end
    if (COUNT_WIDTH < 1) begin : g_bad_count
        $error("galois_lfsr_stream: COUNT_WIDTH must be at least 1");
    end

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                 state_q,      state_d;
    logic [LFSR_WIDTH-1:0]  lfsr_q,       lfsr_d;
    logic [OUT_BITS-1:0]    out_data_q,   out_data_d;
    logic                   out_valid_q,  out_valid_d;
    logic                   seed_err_q,   seed_err_d;
    logic [COUNT_WIDTH-1:0] beat_count_q, beat_count_d;

    // ------------------------------------------------------------------
    // Combinational N-step unroll of the Galois register.
    // Each step shifts left and, if the bit leaving the top was 1, folds the
    // tap mask back in. The bit leaving the top is the output bit, so the
    // first step's bit lands in the MSB of the beat.
    // ------------------------------------------------------------------
    logic [OUT_BITS-1:0]   beat_dat;
    logic [LFSR_WIDTH-1:0] beat_next;

    always_comb begin : beat_unroll
        logic [LFSR_WIDTH-1:0] s;
        s        = lfsr_q;
        beat_dat = '0;
        for (int i = 0; i < OUT_BITS; i++) begin
            beat_dat[OUT_BITS-1-i] = s[LFSR_WIDTH-1];
            s = {s[LFSR_WIDTH-2:0], 1'b0} ^ (s[LFSR_WIDTH-1] ? LFSR_POLY : '0);
        end
        beat_next = s;
    end

    // ------------------------------------------------------------------
    // Handshake and next-state logic
    // ------------------------------------------------------------------
    logic seed_zero;
    logic accept;
    logic gen_beat;

    assign seed_zero = (seed_value == '0);
    assign accept    = out_valid_q && out_ready;
    // A new beat may be produced only into an empty or draining output slot.
    assign gen_beat  = (state_q == ST_RUN) && enable && (!out_valid_q || out_ready);

    always_comb begin
        state_d      = state_q;
        lfsr_d       = lfsr_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        seed_err_d   = 1'b0;
        beat_count_d = beat_count_q;

        if (seed_load) begin
            // Reload wins over everything: any pending beat is discarded and a
            // coincident handshake is not counted.
            lfsr_d       = seed_zero ? LFSR_ONE : seed_value;
            seed_err_d   = seed_zero;
            out_valid_d  = 1'b0;
            beat_count_d = '0;
            state_d      = ST_INIT;
        end else begin
            if (accept) begin
                beat_count_d = beat_count_q + CNT_ONE;
            end

            case (state_q)
                ST_INIT: begin
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (gen_beat) begin
                        out_data_d  = beat_dat;
                        out_valid_d = 1'b1;
                        lfsr_d      = beat_next;
                    end else if (accept) begin
                        out_valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_INIT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_INIT;
            lfsr_q       <= LFSR_SEED;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            seed_err_q   <= 1'b0;
            beat_count_q <= '0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            seed_err_q   <= seed_err_d;
            beat_count_q <= beat_count_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign seed_err   = seed_err_q;
    assign beat_count = beat_count_q;
    assign lfsr_state = lfsr_q;

endmodule

// File: tb/tb_galois_lfsr_stream.sv
module tb_galois_lfsr_stream;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    // Instance A: W=8, POLY=1D, N=1
    logic        a_en, a_rdy, a_sl, a_vld, a_serr;
    logic [7:0]  a_sv, a_st;
    logic [0:0]  a_dat;
    logic [15:0] a_cnt;
    // Instance B: W=8, POLY=1D, N=8
    logic        b_en, b_rdy, b_sl, b_vld, b_serr;
    logic [7:0]  b_sv, b_st, b_dat;
    logic [15:0] b_cnt;
    // Instance C: W=16, POLY=002D, N=5
    logic        c_en, c_rdy, c_sl, c_vld, c_serr;
    logic [15:0] c_sv, c_st, c_cnt;
    logic [4:0]  c_dat;

    galois_lfsr_stream #(.LFSR_WIDTH(8), .LFSR_POLY(8'h1D), .LFSR_SEED(8'h01),
                         .OUT_BITS(1), .COUNT_WIDTH(16)) u_a (
        .clk(clk), .reset_n(reset_n), .enable(a_en), .seed_load(a_sl), .seed_value(a_sv),
        .out_data(a_dat), .out_valid(a_vld), .out_ready(a_rdy), .seed_err(a_serr),
        .beat_count(a_cnt), .lfsr_state(a_st));

    galois_lfsr_stream #(.LFSR_WIDTH(8), .LFSR_POLY(8'h1D), .LFSR_SEED(8'h01),
                         .OUT_BITS(8), .COUNT_WIDTH(16)) u_b (
        .clk(clk), .reset_n(reset_n), .enable(b_en), .seed_load(b_sl), .seed_value(b_sv),
        .out_data(b_dat), .out_valid(b_vld), .out_ready(b_rdy), .seed_err(b_serr),
        .beat_count(b_cnt), .lfsr_state(b_st));

    galois_lfsr_stream #(.LFSR_WIDTH(16), .LFSR_POLY(16'h002D), .LFSR_SEED(16'h0001),
                         .OUT_BITS(5), .COUNT_WIDTH(16)) u_c (
        .clk(clk), .reset_n(reset_n), .enable(c_en), .seed_load(c_sl), .seed_value(c_sv),
        .out_data(c_dat), .out_valid(c_vld), .out_ready(c_rdy), .seed_err(c_serr),
        .beat_count(c_cnt), .lfsr_state(c_st));

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Golden Galois model: N single steps from s, first bit in MSB of the beat.
    function automatic logic [31:0] beat_data(input logic [31:0] s0, input int w,
                                              input logic [31:0] poly, input int n);
        logic [31:0] s, d, msk;
        logic        m;
        msk = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        s = s0;
        d = '0;
        for (int i = 0; i < n; i++) begin
            m = s[w-1];
            d = {d[30:0], m};
            s = ((s << 1) ^ (m ? poly : 32'd0)) & msk;
        end
        return d;
    endfunction

    function automatic logic [31:0] beat_next(input logic [31:0] s0, input int w,
                                              input logic [31:0] poly, input int n);
        logic [31:0] s, msk;
        logic        m;
        msk = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        s = s0;
        for (int i = 0; i < n; i++) begin
            m = s[w-1];
            s = ((s << 1) ^ (m ? poly : 32'd0)) & msk;
        end
        return s;
    endfunction

    // Scoreboards: model state tracks the next beat to be accepted.
    logic [31:0] ms_a, ms_b, ms_c;
    int acc_a, acc_b, acc_c;
    int mis_a = 0;
    int mis_b = 0;
    int mis_c = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ms_a <= 32'd1; acc_a <= 0;
        end else if (a_sl) begin
            ms_a <= (a_sv == 8'h00) ? 32'd1 : 32'(a_sv);
        end else if (a_vld) begin
            if (32'(a_st) !== beat_next(ms_a, 8, 32'h1D, 1)) mis_a <= mis_a + 1;
            if (a_rdy) begin
                acc_a <= acc_a + 1;
                if (32'(a_dat) !== beat_data(ms_a, 8, 32'h1D, 1)) mis_a <= mis_a + 1;
                ms_a <= beat_next(ms_a, 8, 32'h1D, 1);
            end
        end
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ms_b <= 32'd1; acc_b <= 0;
        end else if (b_sl) begin
            ms_b <= (b_sv == 8'h00) ? 32'd1 : 32'(b_sv);
        end else if (b_vld) begin
            if (32'(b_st) !== beat_next(ms_b, 8, 32'h1D, 8)) mis_b <= mis_b + 1;
            if (b_rdy) begin
                acc_b <= acc_b + 1;
                if (32'(b_dat) !== beat_data(ms_b, 8, 32'h1D, 8)) mis_b <= mis_b + 1;
                ms_b <= beat_next(ms_b, 8, 32'h1D, 8);
            end
        end
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ms_c <= 32'd1; acc_c <= 0;
        end else if (c_sl) begin
            ms_c <= (c_sv == 16'h0000) ? 32'd1 : 32'(c_sv);
        end else if (c_vld) begin
            if (32'(c_st) !== beat_next(ms_c, 16, 32'h002D, 5)) mis_c <= mis_c + 1;
            if (c_rdy) begin
                acc_c <= acc_c + 1;
                if (32'(c_dat) !== beat_data(ms_c, 16, 32'h002D, 5)) mis_c <= mis_c + 1;
                ms_c <= beat_next(ms_c, 16, 32'h002D, 5);
            end
        end
    end

    logic [7:0] exp_st [8];
    logic       exp_d  [8];

    initial begin
        exp_st = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1D};
        exp_d  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        reset_n = 1'b1;
        a_en = 0; a_rdy = 0; a_sl = 0; a_sv = '0;
        b_en = 0; b_rdy = 0; b_sl = 0; b_sv = '0;
        c_en = 0; c_rdy = 0; c_sl = 0; c_sv = '0;
        #1 reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // ---- Reset values ----
        chk("rst_a_valid", 64'(a_vld), 64'd0);
        chk("rst_a_data",  64'(a_dat), 64'd0);
        chk("rst_a_state", 64'(a_st),  64'h01);
        chk("rst_a_count", 64'(a_cnt), 64'd0);
        chk("rst_a_serr",  64'(a_serr), 64'd0);
        chk("rst_c_state", 64'(c_st),  64'h0001);

        // ---- A: N=1 sequence ----
        a_en = 1; a_rdy = 1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("a_init_valid", 64'(a_vld), 64'd0);
        chk("a_init_state", 64'(a_st),  64'h01);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("a_seq_state", 64'(a_st),  64'(exp_st[k]));
            chk("a_seq_data",  64'(a_dat), 64'(exp_d[k]));
        end
        repeat (247) @(negedge clk);
        chk("a_period_state", 64'(a_st),  64'h01);
        chk("a_period_count", 64'(a_cnt), 64'd254);
        a_en = 0;
        @(negedge clk);
        chk("a_final_count", 64'(a_cnt), 64'd255);
        chk("a_final_valid", 64'(a_vld), 64'd0);
        chk("a_final_state", 64'(a_st),  64'h01);
        chk("a_stream",      64'(mis_a), 64'd0);

        // ---- B: N=8, backpressure and enable ----
        b_en = 1; b_rdy = 0;
        @(negedge clk);
        chk("b_first_valid", 64'(b_vld), 64'd1);
        chk("b_first_data",  64'(b_dat), 64'h01);
        chk("b_first_state", 64'(b_st),  64'h1D);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("b_bp_data",  64'(b_dat), 64'h01);
            chk("b_bp_state", 64'(b_st),  64'h1D);
            chk("b_bp_count", 64'(b_cnt), 64'd0);
        end
        b_en = 0;
        @(negedge clk);
        chk("b_enlow_valid", 64'(b_vld), 64'd1);
        chk("b_enlow_data",  64'(b_dat), 64'h01);
        b_rdy = 1;
        @(negedge clk);
        chk("b_drain_valid", 64'(b_vld), 64'd0);
        chk("b_drain_count", 64'(b_cnt), 64'd1);
        chk("b_drain_state", 64'(b_st),  64'h1D);
        b_en = 1;
        @(negedge clk);
        chk("b_resume_data",  64'(b_dat), 64'h1C);
        chk("b_resume_state", 64'(b_st),  64'h4C);
        repeat (253) @(negedge clk);
        chk("b_period_state", 64'(b_st),  64'h01);
        chk("b_period_count", 64'(b_cnt), 64'd254);

        for (int i = 0; i < 1000; i++) begin
            b_en  = ($urandom_range(0, 3) != 0);
            b_rdy = $urandom_range(0, 1) == 1;
            @(negedge clk);
        end
        b_en = 0; b_rdy = 1;
        repeat (2) @(negedge clk);
        chk("b_stream",     64'(mis_b), 64'd0);
        chk("b_count_trk",  64'(b_cnt), 64'(acc_b[15:0]));

        // ---- B: zero seed mid-stream ----
        b_en = 1; b_rdy = 0;
        @(negedge clk);
        chk("b_pre_seed_valid", 64'(b_vld), 64'd1);
        b_sl = 1; b_sv = 8'h00; b_rdy = 1;
        @(negedge clk);
        b_sl = 0;
        chk("b_z_serr",  64'(b_serr), 64'd1);
        chk("b_z_state", 64'(b_st),   64'h01);
        chk("b_z_valid", 64'(b_vld),  64'd0);
        chk("b_z_count", 64'(b_cnt),  64'd0);
        @(negedge clk);
        chk("b_z_serr_end", 64'(b_serr), 64'd0);
        chk("b_z_init",     64'(b_vld),  64'd0);
        @(negedge clk);
        chk("b_z_beat_data",  64'(b_dat), 64'h01);
        chk("b_z_beat_state", 64'(b_st),  64'h1D);
        @(negedge clk);
        chk("b_z_count1", 64'(b_cnt), 64'd1);

        // ---- B: seed A5 ----
        b_sl = 1; b_sv = 8'hA5;
        @(negedge clk);
        b_sl = 0;
        chk("b_a5_state", 64'(b_st),   64'hA5);
        chk("b_a5_serr",  64'(b_serr), 64'd0);
        chk("b_a5_valid", 64'(b_vld),  64'd0);
        chk("b_a5_count", 64'(b_cnt),  64'd0);
        @(negedge clk);
        @(negedge clk);
        chk("b_a5_data",  64'(b_dat), 64'hA8);
        chk("b_a5_next",  64'(b_st),  64'hC8);
        repeat (20) @(negedge clk);
        chk("b_stream_reseed", 64'(mis_b), 64'd0);

        // ---- C: W=16 N=5 long run ----
        c_en = 1; c_rdy = 1;
        @(negedge clk);
        chk("c_first_data",  64'(c_dat), 64'h00);
        chk("c_first_state", 64'(c_st),  64'h0020);
        repeat (10000) @(negedge clk);
        chk("c_stream",   64'(mis_c), 64'd0);
        chk("c_accepted", 64'(acc_c), 64'd10000);
        chk("c_count",    64'(c_cnt), 64'd10000);

        // ---- Async reset mid-beat ----
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_c_valid", 64'(c_vld),  64'd0);
        chk("arst_c_data",  64'(c_dat),  64'd0);
        chk("arst_c_state", 64'(c_st),   64'h0001);
        chk("arst_c_count", 64'(c_cnt),  64'd0);
        chk("arst_c_serr",  64'(c_serr), 64'd0);
        chk("arst_b_state", 64'(b_st),   64'h01);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
